fir_ctrl_fsm: RTL

- Sequencing controller for the FIR engine.
- Accepts an ap_start pulse from the AXI-Lite config block, clears the data shift RAM, then runs one sample at a time: accept one AXI-Stream input, issue Tape_Num tap/data RAM address pairs with MAC enables, and emit one AXI-Stream output.
- Drives the ap_start/ap_idle/ap_done status bits read back through AXI-Lite address 0x00.

---
 rtl/fir_ctrl_fsm.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fir_ctrl_fsm.sv
// fir_ctrl_fsm: sequencer for the FIR engine (clear data RAM, per-sample accept/MAC/emit, ap_* status)
module fir_ctrl_fsm #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start_req,
    input  logic                   done_clr,
    input  logic [pDATA_WIDTH-1:0] data_length,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic                   sm_tlast,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [3:0]             data_WE,
    output logic                   data_clr,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic                   tlast_err
);
    localparam int CW = $clog2(Tape_Num + 1);
    localparam logic [CW-1:0] NUM    = CW'(Tape_Num);
    localparam logic [CW-1:0] LAST_K = CW'(Tape_Num - 1);

    typedef enum logic [2:0] {IDLE, INIT, WAIT_IN, MAC, OUT, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          k;
    logic [CW-1:0]          head;
    logic [CW-1:0]          rd_idx;
    logic [pDATA_WIDTH-1:0] len;
    logic [pDATA_WIDTH-1:0] sample_cnt;
    logic                   last;
    logic                   in_hs;
    logic                   mac_rd;

    function automatic logic [pADDR_WIDTH-1:0] addr(input logic [CW-1:0] i);
        return pADDR_WIDTH'({i, 2'b00});
    endfunction

    // Newest sample sits at head; tap k pairs with the sample k steps older, wrapping modulo Tape_Num.
    assign rd_idx    = (head >= k) ? head - k : head + NUM - k;
    assign last      = sample_cnt == len - pDATA_WIDTH'(1);
    assign ss_tready = state == WAIT_IN;
    assign in_hs     = ss_tready & ss_tvalid;
    assign sm_tvalid = state == OUT;
    assign sm_tlast  = sm_tvalid & last;
    assign mac_rd    = state == MAC && k < NUM;
    assign mac_clr   = in_hs;
    // Enable lags the address by one cycle to line up with the RAM read latency.
    assign mac_en    = state == MAC && k != '0;
    assign data_clr  = state == INIT;
    assign data_WE   = (data_clr || in_hs) ? 4'hF : 4'h0;
    assign tap_A     = mac_rd ? addr(k) : '0;
    assign data_A    = data_clr ? addr(k) : ss_tready ? addr(head) : mac_rd ? addr(rd_idx) : '0;

    // Control FSM: state, counters and the registered ap_* / tlast_err status bits.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state      <= IDLE;
            k          <= '0;
            head       <= '0;
            len        <= '0;
            sample_cnt <= '0;
            ap_start   <= 1'b0;
            ap_done    <= 1'b0;
            ap_idle    <= 1'b1;
            tlast_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req && ap_idle) begin
                        state     <= INIT;
                        k         <= '0;
                        len       <= data_length;
                        ap_start  <= 1'b1;
                        ap_idle   <= 1'b0;
                        ap_done   <= 1'b0;
                        tlast_err <= 1'b0;
                    end else if (done_clr) begin
                        ap_done <= 1'b0;
                    end
                end
                INIT: begin
                    k <= k + 1'b1;
                    if (k == LAST_K) begin
                        k          <= '0;
                        head       <= '0;
                        sample_cnt <= '0;
                        state      <= (len == '0) ? DONE : WAIT_IN;
                    end
                end
                WAIT_IN: begin
                    if (ss_tvalid) begin
                        state    <= MAC;
                        k        <= '0;
                        ap_start <= 1'b0;
                        if (ss_tlast != last) tlast_err <= 1'b1;
                    end
                end
                MAC: begin
                    k <= k + 1'b1;
                    if (k == NUM) begin
                        k     <= '0;
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (sm_tready) begin
                        head       <= (head == LAST_K) ? '0 : head + 1'b1;
                        sample_cnt <= sample_cnt + 1'b1;
                        state      <= last ? DONE : WAIT_IN;
                    end
                end
                DONE: begin
                    ap_done  <= 1'b1;
                    ap_idle  <= 1'b1;
                    ap_start <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
